// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode and funct
// field values, ALU control encodings and the controller state encoding.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEMADR  = 4'd2,
      ST_MEMRD   = 4'd3,
      ST_MEMWB   = 4'd4,
      ST_MEMWR   = 4'd5,
      ST_EXECUTE = 4'd6,
      ST_ALUWB   = 4'd7,
      ST_BRANCH  = 4'd8,
      ST_BNE     = 4'd9,
      ST_ADDIEX  = 4'd10,
      ST_ADDIWB  = 4'd11,
      ST_JUMP    = 4'd12
   } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
//   inputs to controller : op, funct (from IR), zero (ALU flag), memReady
//   outputs of controller: memory, PC/IR, ALU mux, register file controls
//                          and the instrDone / illegalOp / busErr pulses
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memReady;

   logic       memReq;
   logic       memWrite;
   logic       iOrD;
   logic       irWrite;
   logic       pcEn;
   logic [1:0] pcSrc;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [2:0] aluControl;
   logic       regDst;
   logic       memToReg;
   logic       regWrite;
   logic       instrDone;
   logic       illegalOp;
   logic       busErr;

   modport master (
      input  op, funct, zero, memReady,
      output memReq, memWrite, iOrD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB,
             aluControl, regDst, memToReg, regWrite, instrDone, illegalOp, busErr
   );

   modport slave (
      output op, funct, zero, memReady,
      input  memReq, memWrite, iOrD, irWrite, pcEn, pcSrc, aluSrcA, aluSrcB,
             aluControl, regDst, memToReg, regWrite, instrDone, illegalOp, busErr
   );
endinterface

// File: rtl/mc_alu_funct_dec.sv
// R-type funct decoder: maps instr[5:0] to the ALU control code and flags
// whether the funct is one the datapath implements.
//   i_funct         funct field
//   o_alu_control   ALU operation encoding
//   o_valid         1 when i_funct is add/sub/and/or/slt
module mc_alu_funct_dec
   import mips_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_control,
   output logic       o_valid
);

   always_comb begin
      o_alu_control = ALU_ADD;
      o_valid       = 1'b1;
      case (i_funct)
         FN_ADD:  o_alu_control = ALU_ADD;
         FN_SUB:  o_alu_control = ALU_SUB;
         FN_AND:  o_alu_control = ALU_AND;
         FN_OR:   o_alu_control = ALU_OR;
         FN_SLT:  o_alu_control = ALU_SLT;
         default: o_valid       = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory-ready handshake and watchdog.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   bus       multicycle_controller_if.master (datapath controls/status)
// Parameters: MEM_TIMEOUT (wait cycles before busErr, 0 = no watchdog),
//             TW (watchdog counter width).
// Optional: define MULTICYCLE_BNE_EN to decode bne (op 000101).
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 on memReady
// DECODE   | precompute branch target, dispatch on op
// MEMADR   | compute lw/sw address regA + signImm
// MEMRD    | load data read, wait for memReady
// MEMWB    | write load data to rt
// MEMWR    | store write, wait for memReady
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALU result to rd
// BRANCH   | beq compare, take branch on zero
// BNE      | bne compare, take branch on ~zero
// ADDIEX   | regA + signImm
// ADDIWB   | write addi result to rt
// JUMP     | load jump target into PC
module multicycle_controller
   import mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TW          = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   multicycle_controller_if.master bus
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_idle;
   logic [TW-1:0]   r_wd_cnt;
   logic            w_mem_wait;
   logic            w_timeout;
   logic [2:0]      w_fn_alu;
   logic            w_fn_valid;

   mc_alu_funct_dec u_funct_dec (
      .i_funct       (bus.funct),
      .o_alu_control (w_fn_alu),
      .o_valid       (w_fn_valid)
   );

   // r_idle marks a cycle with no access presented: the partial cycle after
   // reset release and the cycle after a bus error, so memReq visibly drops
   // before the refetch.
   assign w_mem_wait = !r_idle && !bus.memReady &&
                       (r_state inside {ST_FETCH, ST_MEMRD, ST_MEMWR});
   assign w_timeout  = (MEM_TIMEOUT != 0) && w_mem_wait &&
                       (r_wd_cnt == TW'(MEM_TIMEOUT));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_FETCH;
         r_idle   <= 1'b1;
         r_wd_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idle  <= w_timeout;
         if ((MEM_TIMEOUT != 0) && w_mem_wait && !w_timeout)
            r_wd_cnt <= r_wd_cnt + 1'b1;
         else
            r_wd_cnt <= '0;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      bus.memReq     = 1'b0;
      bus.memWrite   = 1'b0;
      bus.iOrD       = 1'b0;
      bus.irWrite    = 1'b0;
      bus.pcEn       = 1'b0;
      bus.pcSrc      = 2'b00;
      bus.aluSrcA    = 1'b0;
      bus.aluSrcB    = 2'b00;
      bus.aluControl = ALU_AND;
      bus.regDst     = 1'b0;
      bus.memToReg   = 1'b0;
      bus.regWrite   = 1'b0;
      bus.instrDone  = 1'b0;
      bus.illegalOp  = 1'b0;
      bus.busErr     = 1'b0;

      if (!r_idle) begin
         case (r_state)
            ST_FETCH: begin
               bus.memReq     = 1'b1;
               bus.aluSrcB    = 2'b01;
               bus.aluControl = ALU_ADD;
               if (bus.memReady) begin
                  bus.irWrite = 1'b1;
                  bus.pcEn    = 1'b1;
                  w_state_nxt = ST_DECODE;
               end
            end
            ST_DECODE: begin
               bus.aluSrcB    = 2'b11;
               bus.aluControl = ALU_ADD;
               case (bus.op)
                  OP_LW, OP_SW: w_state_nxt = ST_MEMADR;
                  OP_RTYPE:     w_state_nxt = ST_EXECUTE;
                  OP_BEQ:       w_state_nxt = ST_BRANCH;
                  OP_ADDI:      w_state_nxt = ST_ADDIEX;
                  OP_J:         w_state_nxt = ST_JUMP;
`ifdef MULTICYCLE_BNE_EN
                  OP_BNE:       w_state_nxt = ST_BNE;
`endif
                  default: begin
                     bus.illegalOp = 1'b1;
                     w_state_nxt   = ST_FETCH;
                  end
               endcase
            end
            ST_MEMADR: begin
               bus.aluSrcA    = 1'b1;
               bus.aluSrcB    = 2'b10;
               bus.aluControl = ALU_ADD;
               w_state_nxt    = (bus.op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
               bus.memReq = 1'b1;
               bus.iOrD   = 1'b1;
               if (bus.memReady) w_state_nxt = ST_MEMWB;
            end
            ST_MEMWB: begin
               bus.memToReg  = 1'b1;
               bus.regWrite  = 1'b1;
               bus.instrDone = 1'b1;
               w_state_nxt   = ST_FETCH;
            end
            ST_MEMWR: begin
               bus.memReq   = 1'b1;
               bus.memWrite = 1'b1;
               bus.iOrD     = 1'b1;
               if (bus.memReady) begin
                  bus.instrDone = 1'b1;
                  w_state_nxt   = ST_FETCH;
               end
            end
            ST_EXECUTE: begin
               bus.aluSrcA    = 1'b1;
               bus.aluControl = w_fn_alu;
               if (w_fn_valid) begin
                  w_state_nxt = ST_ALUWB;
               end else begin
                  bus.illegalOp = 1'b1;
                  w_state_nxt   = ST_FETCH;
               end
            end
            ST_ALUWB: begin
               bus.regDst    = 1'b1;
               bus.regWrite  = 1'b1;
               bus.instrDone = 1'b1;
               w_state_nxt   = ST_FETCH;
            end
            ST_BRANCH, ST_BNE: begin
               bus.aluSrcA    = 1'b1;
               bus.aluControl = ALU_SUB;
               bus.pcSrc      = 2'b01;
               bus.pcEn       = (r_state == ST_BNE) ? !bus.zero : bus.zero;
               bus.instrDone  = 1'b1;
               w_state_nxt    = ST_FETCH;
            end
            ST_ADDIEX: begin
               bus.aluSrcA    = 1'b1;
               bus.aluSrcB    = 2'b10;
               bus.aluControl = ALU_ADD;
               w_state_nxt    = ST_ADDIWB;
            end
            ST_ADDIWB: begin
               bus.regWrite  = 1'b1;
               bus.instrDone = 1'b1;
               w_state_nxt   = ST_FETCH;
            end
            ST_JUMP: begin
               bus.pcSrc     = 2'b10;
               bus.pcEn      = 1'b1;
               bus.instrDone = 1'b1;
               w_state_nxt   = ST_FETCH;
            end
            default: w_state_nxt = ST_FETCH;
         endcase

         // Watchdog expiry abandons the access; the memory-state outputs stay
         // up for this cycle and the instruction restarts from FETCH.
         if (w_timeout) begin
            bus.busErr  = 1'b1;
            w_state_nxt = ST_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   localparam int T = 4;
`ifdef MULTICYCLE_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   localparam logic [5:0] M_RTYPE = 6'b000000, M_LW = 6'b100011, M_SW = 6'b101011,
                          M_BEQ = 6'b000100, M_BNE = 6'b000101, M_ADDI = 6'b001000,
                          M_J = 6'b000010;

   typedef struct {
      string      name;
      int         kind;     // 1 instrDone, 2 illegalOp, 4 busErr
      int         cycles;
      int         mreq;
      int         mwr;
      int         irw;
      int         pcen;
      int         regw;
      int         rdst;
      int         m2r;
      int         psrc;
      bit         chk_alu;
      int         alu;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   multicycle_controller_if bus();

   multicycle_controller #(.MEM_TIMEOUT(T), .TW(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   logic [19:0] all_o;
   assign all_o = {bus.memReq, bus.memWrite, bus.iOrD, bus.irWrite, bus.pcEn, bus.pcSrc,
                   bus.aluSrcA, bus.aluSrcB, bus.aluControl, bus.regDst, bus.memToReg,
                   bus.regWrite, bus.instrDone, bus.illegalOp, bus.busErr};

   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   bit   after_err = 1'b0;
   exp_t q[$];

   task automatic chk(input string nm, input string fld, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
      end
   endtask

   // {valid, alu code} for an R-type funct
   function automatic logic [3:0] fn_model(input logic [5:0] fn);
      case (fn)
         6'b100000: return {1'b1, 3'b010};
         6'b100010: return {1'b1, 3'b110};
         6'b100100: return {1'b1, 3'b000};
         6'b100101: return {1'b1, 3'b001};
         6'b101010: return {1'b1, 3'b111};
         default:   return 4'b0000;
      endcase
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int   c_cyc, c_mreq, c_mwr, c_irw, c_pcen, c_regw, c_rdst, c_m2r, c_psrc, c_alu;
   exp_t m_e;

   always @(negedge clk) begin
      if (mon_en) begin
         c_cyc++;
         if (bus.memReq)   c_mreq++;
         if (bus.memWrite) c_mwr++;
         if (bus.irWrite)  c_irw++;
         if (bus.pcEn) begin
            c_pcen++;
            c_psrc = int'(bus.pcSrc);
         end
         if (bus.regWrite) begin
            c_regw++;
            c_rdst = int'(bus.regDst);
            c_m2r  = int'(bus.memToReg);
         end
         if (bus.aluSrcA && bus.aluSrcB == 2'b00) c_alu = int'(bus.aluControl);
         if (bus.instrDone || bus.illegalOp || bus.busErr) begin
            if (q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_event: got events %b, expected none",
                        {bus.busErr, bus.illegalOp, bus.instrDone});
            end else begin
               m_e = q.pop_front();
               chk(m_e.name, "event",    int'({bus.busErr, bus.illegalOp, bus.instrDone}), m_e.kind);
               chk(m_e.name, "cycles",   c_cyc,  m_e.cycles);
               chk(m_e.name, "memReq",   c_mreq, m_e.mreq);
               chk(m_e.name, "memWrite", c_mwr,  m_e.mwr);
               chk(m_e.name, "irWrite",  c_irw,  m_e.irw);
               chk(m_e.name, "pcEn",     c_pcen, m_e.pcen);
               chk(m_e.name, "pcSrc",    c_psrc, m_e.psrc);
               chk(m_e.name, "regWrite", c_regw, m_e.regw);
               chk(m_e.name, "regDst",   c_rdst, m_e.rdst);
               chk(m_e.name, "memToReg", c_m2r,  m_e.m2r);
               if (m_e.chk_alu) chk(m_e.name, "aluControl", c_alu, m_e.alu);
            end
            c_cyc = 0; c_mreq = 0; c_mwr = 0; c_irw = 0; c_pcen = 0; c_regw = 0;
            c_rdst = 0; c_m2r = 0; c_psrc = 0; c_alu = 0;
         end
      end
   end

   // ---------------- reference model + driver ----------------
   // Builds the per-cycle memReady schedule and the expected retirement
   // summary from the instruction class, wait counts and timeout limit.
   task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int wf, input int wm);
      exp_t e;
      int   rdy[$];
      logic [3:0] fm;
      bit   taken;
      e.name = nm; e.kind = 1; e.mreq = 0; e.mwr = 0; e.irw = 0; e.pcen = 0;
      e.regw = 0; e.rdst = 0; e.m2r = 0; e.psrc = 0; e.chk_alu = 1'b0; e.alu = 0;
      if (after_err) rdy.push_back(int'($urandom_range(0, 1)));
      after_err = 1'b0;
      if (wf >= T) begin
         repeat (T + 1) rdy.push_back(0);
         e.kind = 4; e.mreq = T + 1; after_err = 1'b1;
      end else begin
         repeat (wf) rdy.push_back(0);
         rdy.push_back(1);
         e.mreq = wf + 1; e.irw = 1; e.pcen = 1;
         rdy.push_back(int'($urandom_range(0, 1)));          // decode
         if (op == M_LW || op == M_SW) begin
            rdy.push_back(int'($urandom_range(0, 1)));       // address
            if (wm >= T) begin
               repeat (T + 1) rdy.push_back(0);
               e.kind = 4; e.mreq += T + 1; after_err = 1'b1;
               if (op == M_SW) e.mwr = T + 1;
            end else begin
               repeat (wm) rdy.push_back(0);
               rdy.push_back(1);
               e.mreq += wm + 1;
               if (op == M_SW) e.mwr = wm + 1;
               else begin
                  rdy.push_back(int'($urandom_range(0, 1)));
                  e.regw = 1; e.m2r = 1;
               end
            end
         end else if (op == M_RTYPE) begin
            rdy.push_back(int'($urandom_range(0, 1)));
            fm = fn_model(fn);
            if (fm[3]) begin
               rdy.push_back(int'($urandom_range(0, 1)));
               e.regw = 1; e.rdst = 1; e.chk_alu = 1'b1; e.alu = int'(fm[2:0]);
            end else e.kind = 2;
         end else if (op == M_BEQ || (BNE_EN && op == M_BNE)) begin
            rdy.push_back(int'($urandom_range(0, 1)));
            taken = (op == M_BEQ) ? z : !z;
            e.chk_alu = 1'b1; e.alu = 3'b110;
            if (taken) begin e.pcen = 2; e.psrc = 1; end
         end else if (op == M_ADDI) begin
            rdy.push_back(int'($urandom_range(0, 1)));
            rdy.push_back(int'($urandom_range(0, 1)));
            e.regw = 1;
         end else if (op == M_J) begin
            rdy.push_back(int'($urandom_range(0, 1)));
            e.pcen = 2; e.psrc = 2;
         end else e.kind = 2;
      end
      e.cycles = rdy.size();
      q.push_back(e);
      for (int i = 0; i < rdy.size(); i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            bus.op = op; bus.funct = fn; bus.zero = z; mon_en = 1'b1;
         end
         bus.memReady = rdy[i][0];
      end
   endtask

   task automatic chk_now(input string nm, input logic [19:0] act, input logic [19:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: run did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [5:0] op, fn;
      int sel, wf, wm;
      bus.op = '0; bus.funct = '0; bus.zero = 1'b0; bus.memReady = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk_now("reset_outputs", all_o, 20'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk_now("post_release_idle", all_o, 20'd0);

      run_instr("lw_0wait",    M_LW,    6'd0,      1'b0, 0, 0);
      run_instr("sw_3wait",    M_SW,    6'd0,      1'b0, 0, 3);
      run_instr("beq_taken",   M_BEQ,   6'd0,      1'b1, 0, 0);
      run_instr("beq_nottake", M_BEQ,   6'd0,      1'b0, 0, 0);
      run_instr("r_sub",       M_RTYPE, 6'b100010, 1'b0, 0, 0);
      run_instr("r_badfunct",  M_RTYPE, 6'b111111, 1'b0, 0, 0);
      run_instr("fetch_tmo",   M_LW,    6'd0,      1'b0, 9, 0);
      run_instr("j_after_tmo", M_J,     6'd0,      1'b0, 0, 0);
      run_instr("addi_1wait",  M_ADDI,  6'd0,      1'b0, 1, 0);
      run_instr("bad_op",      6'b111111, 6'd0,    1'b0, 0, 0);
      run_instr("bne_nz",      M_BNE,   6'd0,      1'b0, 0, 0);
      run_instr("lw_rd_tmo",   M_LW,    6'd0,      1'b0, 0, 7);
      run_instr("sw_wr_tmo",   M_SW,    6'd0,      1'b0, 2, 5);
      run_instr("lw_3wait",    M_LW,    6'd0,      1'b0, 3, 3);

      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 8));
         fn  = 6'($urandom);
         case (sel)
            0: op = M_LW;
            1: op = M_SW;
            2: begin
               op = M_RTYPE;
               case ($urandom_range(0, 4))
                  0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
                  3: fn = 6'b100101; default: fn = 6'b101010;
               endcase
            end
            3: op = M_RTYPE;
            4: op = M_BEQ;
            5: op = M_BNE;
            6: op = M_ADDI;
            7: op = M_J;
            default: op = 6'($urandom);
         endcase
         wf = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 6));
         wm = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 6));
         run_instr("random", op, fn, 1'($urandom), wf, wm);
      end

      @(posedge clk);
      #1;
      mon_en = 1'b0;
      bus.memReady = 1'b0;
      n_vec++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL pending_expect: got %0d outstanding, expected 0", q.size());
      end

      // Reset during a load's MEMRD wait, then restart cleanly.
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      @(posedge clk); #1; bus.op = M_LW; bus.memReady = 1'b1;   // FETCH
      @(posedge clk); #1; bus.memReady = 1'b0;                  // DECODE
      @(posedge clk); #1;                                       // MEMADR
      @(posedge clk); #1;                                       // MEMRD
      @(negedge clk);
      chk_now("memrd_req_iord", {bus.memReq, bus.iOrD, bus.regWrite}, 20'b110);
      #2;
      reset_n = 1'b0;
      #1;
      chk_now("async_reset_zero", all_o, 20'd0);
      bus.memReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_now("reset_held_zero", all_o, 20'd0);
      reset_n = 1'b1;
      @(negedge clk);
      chk_now("release_idle_zero", all_o, 20'd0);
      @(posedge clk); #1; bus.memReady = 1'b0;
      @(negedge clk);
      chk_now("refetch_1", {bus.memReq, bus.iOrD, bus.irWrite, bus.pcEn, bus.regWrite}, 20'b10000);
      @(posedge clk); #1;
      @(negedge clk);
      chk_now("refetch_2", {bus.memReq, bus.iOrD, bus.irWrite, bus.pcEn, bus.regWrite}, 20'b10000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
